// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: route FSM encoding,
// drop counter width and the saturating increment used by the drop counter.
package demux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } route_state_e;

    localparam int DROP_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        logic [DROP_CNT_W-1:0] result;
        if (value == {DROP_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice for a single output channel. The slot accepts a
// new beat whenever it is empty or is being drained in the same cycle, so a
// channel with a permanently ready consumer runs at full throughput.
module demux_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             free,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             last_r;

    assign free      = ~valid_r | out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_last  = last_r;

    // Slot contents: a load wins over a drain so a simultaneous load/drain keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
            last_r  <= in_last;
        end else if (out_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= valid_r;
            last_r  <= last_r;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware stream demultiplexer. The head beat of each packet picks an
// output channel via in_sel; the choice is held until the last beat. Packets
// addressed to a nonexistent channel are swallowed, flagged on err per beat
// and counted in drop_cnt.
module stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NOUT  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_last,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic [NOUT-1:0]       out_last,
    output logic                  err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int NPAD = 1 << SELW;

    route_state_e          state_r;
    route_state_e          state_next_s;
    logic [SELW-1:0]       route_r;
    logic [SELW-1:0]       route_s;
    logic                  legal_s;
    logic                  accept_s;
    logic                  drop_s;
    logic [NOUT-1:0]       slot_free_s;
    logic [NPAD-1:0]       free_pad_s;
    logic [NOUT-1:0]       load_s;
    logic                  err_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    assign route_s  = (state_r == ST_IDLE) ? in_sel : route_r;
    assign legal_s  = ({1'b0, route_s} < (SELW+1)'(NOUT));
    assign accept_s = in_valid & in_ready;
    assign drop_s   = accept_s & ~legal_s;
    assign err      = err_r;
    assign drop_cnt = drop_cnt_r;

    // Free flags padded to every encodable route; nonexistent channels always read free.
    always_comb begin
        free_pad_s = {NPAD{1'b1}};
        for (int k = 0; k < NOUT; k++) begin
            free_pad_s[k] = slot_free_s[k];
        end
    end

    assign in_ready = free_pad_s[route_s];

    // One-hot load strobe for the addressed slot; dropped beats load nothing.
    always_comb begin
        load_s = {NOUT{1'b0}};
        for (int k = 0; k < NOUT; k++) begin
            load_s[k] = accept_s & legal_s & (route_s == SELW'(k));
        end
    end

    // Route FSM next state: lock onto a route after a non-final accepted beat.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !in_last) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && in_last) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Route FSM state and latched route (refreshed on every accepted beat).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            route_r <= {SELW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                route_r <= route_s;
            end else begin
                route_r <= route_r;
            end
        end
    end

    // Drop reporting: err follows each discarded beat; count packets on their final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r      <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            err_r <= drop_s;
            if (drop_s && in_last) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_s[k]),
            .out_ready (out_ready[k]),
            .in_data   (in_data),
            .in_last   (in_last),
            .free      (slot_free_s[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH]),
            .out_last  (out_last[k])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel instance for routing, back-pressure
// and reset behaviour, and a 3-channel instance for illegal-route drops.
module tb_stream_demux;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] data;
        logic        last;
        int          exp_ch;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_last;
    logic        err;
    logic [7:0]  drop_cnt;

    logic        b_rst;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_last;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [47:0] b_out_data;
    logic [2:0]  b_out_last;
    logic        b_err;
    logic [7:0]  b_drop_cnt;

    int    tests = 0;
    int    fails = 0;
    beat_t sb_q[4][$];

    always #5 clk = ~clk;

    stream_demux u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err), .drop_cnt(drop_cnt)
    );

    stream_demux #(.WIDTH(16), .NOUT(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .err(b_err), .drop_cnt(b_drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drains observed at negedge are checked against the per-channel scoreboard.
    task automatic monitor();
        beat_t b;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sb_q[k].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected ch%0d: got data 0x%0h expected no beat", k, out_data[k*16 +: 16]);
                    end else begin
                        b = sb_q[k].pop_front();
                        chk($sformatf("sb_data ch%0d", k), 32'(out_data[k*16 +: 16]), 32'(b.data));
                        chk($sformatf("sb_last ch%0d", k), 32'(out_last[k]), 32'(b.last));
                    end
                end
            end
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, record the expected output.
    task automatic send(input logic [1:0] sel, input logic [15:0] data, input logic last, input int exp_ch);
        logic  acc;
        beat_t b;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc    = 1'b1;
                b.data = data;
                b.last = last;
                if (exp_ch >= 0) sb_q[exp_ch].push_back(b);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            chk("send_timeout", 32'(acc), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int   err_seen;
        logic any_out;

        vecs[0] = '{sel: 2'd0, data: 16'hA000, last: 1'b1, exp_ch: 0};
        vecs[1] = '{sel: 2'd1, data: 16'hA001, last: 1'b1, exp_ch: 1};
        vecs[2] = '{sel: 2'd2, data: 16'hA002, last: 1'b1, exp_ch: 2};
        vecs[3] = '{sel: 2'd3, data: 16'hA003, last: 1'b1, exp_ch: 3};
        vecs[4] = '{sel: 2'd3, data: 16'h5A5A, last: 1'b1, exp_ch: 3};
        vecs[5] = '{sel: 2'd1, data: 16'hFFFF, last: 1'b1, exp_ch: 1};

        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_sel = 2'd0; in_last = 1'b0;
        out_ready = 4'hF;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = 16'h0000; b_in_sel = 2'd0; b_in_last = 1'b0;
        b_out_ready = 3'b111;

        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_out_data", out_data[31:0], 32'h0);
        chk("rst_out_data_hi", out_data[63:32], 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_rst = 1'b0;

        // Single-beat packets: one-cycle latency onto the selected channel
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sel = vecs[i].sel; in_data = vecs[i].data; in_last = vecs[i].last;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'h1);
            sb_q[vecs[i].exp_ch].push_back('{data: vecs[i].data, last: vecs[i].last});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(4'b0001 << vecs[i].exp_ch));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data[vecs[i].exp_ch*16 +: 16]), 32'(vecs[i].data));
            @(posedge clk);
            #1;
        end

        // Multi-beat packet: route held despite in_sel changing
        send(2'd2, 16'hB000, 1'b0, 2);
        send(2'd0, 16'hB001, 1'b0, 2);
        send(2'd0, 16'hB002, 1'b1, 2);
        @(negedge clk);
        chk("pkt_out_last_ch2", 32'(out_last), 32'(4'b0100));
        @(posedge clk);
        #1;

        // Back-pressure on channel 1 while other channels keep flowing
        out_ready = 4'b1101;
        send(2'd1, 16'hC000, 1'b1, 1);
        send(2'd3, 16'hC010, 1'b1, 3);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'hC001; in_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall_in_ready_%0d", c), 32'(in_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        out_ready = 4'hF;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'h1);
        sb_q[1].push_back('{data: 16'hC001, last: 1'b1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_out_valid1", 32'(out_valid[1]), 32'h1);
        chk("release_out_data1", 32'(out_data[31:16]), 32'h0000C001);
        @(posedge clk);
        #1;
        send(2'd3, 16'hC002, 1'b1, 3);

        // Reset in the middle of a packet
        send(2'd0, 16'hD000, 1'b0, 0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) sb_q[k].delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_last", 32'(out_last), 32'h0);
        chk("midrst_out_data", out_data[31:0], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'd2, 16'hD001, 1'b1, 2);
        @(negedge clk);
        chk("postrst_out_valid", 32'(out_valid), 32'(4'b0100));
        chk("postrst_out_data2", 32'(out_data[47:32]), 32'h0000D001);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sb_drained ch%0d", k), 32'(sb_q[k].size()), 32'h0);
        end

        // Illegal route on the 3-channel instance
        any_out = 1'b0;
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 16'hE000; b_in_last = 1'b0;
        @(negedge clk);
        chk("drop_in_ready_b1", 32'(b_in_ready), 32'h1);
        @(posedge clk);
        #1;
        b_in_sel = 2'd0; b_in_data = 16'hE001; b_in_last = 1'b1;
        @(negedge clk);
        chk("drop_in_ready_b2", 32'(b_in_ready), 32'h1);
        chk("drop_err_b1", 32'(b_err), 32'h1);
        any_out = any_out | (|b_out_valid);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("drop_err_b2", 32'(b_err), 32'h1);
        chk("drop_cnt_1", 32'(b_drop_cnt), 32'h1);
        any_out = any_out | (|b_out_valid);
        @(negedge clk);
        chk("drop_err_idle", 32'(b_err), 32'h0);
        chk("drop_no_out_valid", 32'(any_out), 32'h0);

        // Saturation: 255 more dropped 2-beat packets
        err_seen = 0;
        @(posedge clk);
        #1;
        for (int p = 0; p < 255; p++) begin
            b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 16'(p); b_in_last = 1'b0;
            @(negedge clk);
            if (b_err) err_seen++;
            any_out = any_out | (|b_out_valid);
            @(posedge clk);
            #1;
            b_in_sel = 2'd1; b_in_last = 1'b1;
            @(negedge clk);
            if (b_err) err_seen++;
            any_out = any_out | (|b_out_valid);
            @(posedge clk);
            #1;
            if (p == 253) chk("drop_cnt_255", 32'(b_drop_cnt), 32'd255);
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        if (b_err) err_seen++;
        @(negedge clk);
        if (b_err) err_seen++;
        chk("drop_err_pulses", 32'(err_seen), 32'd510);
        chk("drop_cnt_sat", 32'(b_drop_cnt), 32'd255);
        chk("drop_loop_no_out_valid", 32'(any_out), 32'h0);

        // A legal packet after drops is routed normally
        @(posedge clk);
        #1;
        b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 16'hE100; b_in_last = 1'b1;
        @(negedge clk);
        chk("legal_after_drop_ready", 32'(b_in_ready), 32'h1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("legal_after_drop_valid", 32'(b_out_valid), 32'(3'b010));
        chk("legal_after_drop_data", 32'(b_out_data[31:16]), 32'h0000E100);
        chk("legal_after_drop_err", 32'(b_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 16, data beat width in bits.
REQ-002 Parameter NOUT, default 4, number of output channels; legal range 2..16.
REQ-003 Parameter SELW, default 2, select width; SHALL equal ceil(log2(NOUT)).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_data  input  WIDTH  beat payload.
REQ-009 in_sel  input  SELW  destination channel; sampled only on the first beat of a packet.
REQ-010 in_last  input  1  final beat of packet.
REQ-011 out_valid  output  NOUT  per-channel beat present.
REQ-012 out_ready  input  NOUT  per-channel downstream accept.
REQ-013 out_data  output  NOUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 out_last  output  NOUT  per-channel last flag.
REQ-015 err  output  1  one-cycle pulse per dropped beat.
REQ-016 drop_cnt  output  8  count of dropped packets, saturating at 255.

Function
REQ-017 Transfer occurs on a channel when valid and ready are both high on a rising edge; input transfer = in_valid & in_ready.
REQ-018 Each channel SHALL hold one registered slot (data, last, valid); out_* driven directly from slot registers, no combinational path from in_data to out_data.
REQ-019 Slot k SHALL be free when empty, or when full and out_ready[k] is high in the same cycle (pass-through at full throughput).
REQ-020 Route state machine: IDLE, LOCKED. IDLE -> LOCKED on an accepted beat with in_last=0; LOCKED -> IDLE on an accepted beat with in_last=1; single-beat packets stay in IDLE.
REQ-021 In IDLE the route SHALL be in_sel; the route is latched on acceptance. In LOCKED the latched route is used and in_sel is ignored.
REQ-022 in_ready SHALL equal "slot[route] free" for a legal route; in_ready depends only on state, in_sel (IDLE) and out_ready, never on in_valid.
REQ-023 Latency: a beat accepted at edge t SHALL appear on out_valid of its channel after edge t (one cycle).
REQ-024 Illegal route (in_sel >= NOUT): in_ready=1; beat is discarded, err pulses high in the following cycle; route is latched so all remaining beats of that packet are discarded, each pulsing err.
REQ-025 drop_cnt SHALL increment once per dropped packet, on the beat with in_last=1, and hold at 255.
REQ-026 Slots drain independently; a stalled channel SHALL NOT block beats routed to other channels when in IDLE.
REQ-027 A slot being loaded and drained in the same cycle SHALL keep out_valid high with the new beat.
REQ-028 Beat order within each channel SHALL be preserved; no beat duplicated or lost except per REQ-024.

Reset
REQ-029 While rst is high: out_valid=0, out_last=0, out_data=0, err=0, drop_cnt=0, state=IDLE, latched route=0; in_ready follows REQ-022 from the reset state.
REQ-030 Assertion of rst mid-packet SHALL abandon the packet; the next accepted beat after release is treated as a packet head.

Structure
REQ-031 Shared package/header demux_pkg SHALL hold the state encodings (IDLE=0, LOCKED=1) and drop counter width (8).
REQ-032 One sub-module demux_slot (one-entry register slice: load, drain, free flag) SHALL be instantiated NOUT times via generate.

Verification
REQ-033 All out_ready=1, single-beat packets with in_sel 0,1,2,3, data 0xA000..0xA003 -> each appears on matching channel one cycle later, in_ready constantly 1.
REQ-034 3-beat packet to channel 2, in_sel changed to 0 on beats 2-3 -> all three beats on channel 2 in order, out_last only on third.
REQ-035 out_ready[1]=0, slot 1 full, packet to channel 1 then single beat to channel 3 -> in_ready=0 while addressing 1; releasing out_ready[1] drains 1 and accepts the beat in the same cycle.
REQ-036 NOUT=3, 2-beat packet with in_sel=3 -> both beats accepted, err pulses twice, no out_valid, drop_cnt=1; 256 such packets -> drop_cnt=255.
REQ-037 rst asserted after beat 1 of a 4-beat packet to channel 0 -> all out_valid=0 immediately; next beat with in_sel=2 routes to channel 2.
